alu_uart_if: RTL and testbench
==============================

# alu_uart_if

Sequencer between the UART and the ALU. It collects three bytes from the UART receiver: operand A, operand B, then the opcode. It drives them onto the ALU inputs and registers the combinational result and flags. It then returns two bytes through the UART transmitter: the result, then a flags byte. It sits in the top-level wrapper between the UART RX/TX blocks and the ALU, and is the only master of both.

## Interface
- N, 8, data/operand width; must equal UART data width and ALU N; N >= 6.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a new received byte.
- rx_data  in  N  received byte, valid only with rx_done_tick.
- tx_done_tick  in  1  one-cycle pulse: transmitter finished the current byte.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  N  byte to transmit; stable from tx_start until tx_done_tick.
- alu_a  out  N  registered operand A to ALU.
- alu_b  out  N  registered operand B to ALU.
- alu_op  out  6  registered opcode to ALU (rx_data[5:0] of third byte).
- alu_result  in  N  ALU combinational result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow flag.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
- WAIT_A: on rx_done_tick, alu_a <= rx_data, go to WAIT_B.
- WAIT_B: on rx_done_tick, alu_b <= rx_data, go to WAIT_OP.
- WAIT_OP: on rx_done_tick, alu_op <= rx_data[5:0], go to EXEC. Upper bits rx_data[N-1:6] are ignored.
- EXEC: res_reg <= alu_result, flg_reg <= {(N-2) zeros, alu_carry, alu_zero}, go to SEND_RES.
- SEND_RES: tx_start = 1 and tx_data = res_reg, go to WAIT_RES.
- WAIT_RES: hold tx_data. On tx_done_tick, go to SEND_FLG.
- SEND_FLG: tx_start = 1 and tx_data = flg_reg, go to WAIT_FLG.
- WAIT_FLG: on tx_done_tick, go to WAIT_A.
- rx_done_tick outside WAIT_A/WAIT_B/WAIT_OP is dropped; no buffering. This covers a byte arriving in the same cycle as the final tx_done_tick.
- tx_done_tick outside WAIT_RES/WAIT_FLG is ignored.
- Operand registers hold their values after a transaction until overwritten. Undefined opcodes are passed through; the ALU returns 0 with zero = 1.
- Reset (any state, mid-transaction included): state <= WAIT_A; alu_a, alu_b, alu_op, res_reg, flg_reg, tx_data <= 0; tx_start <= 0. A partially received triple is discarded.

## Timing
- tx_start is registered and high for exactly one cycle per byte; never two pulses without an intervening tx_done_tick.
- Latency from opcode rx_done_tick (cycle t) to the result tx_start:
  - alu_op is updated at edge t+1.
  - EXEC samples the ALU at edge t+2.
  - tx_start is high in cycle t+2..t+3, i.e. two edges after the opcode pulse.
- The ALU has one full cycle (alu_op stable) to settle before EXEC samples it.
- The flags tx_start is two edges after the result byte's tx_done_tick.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding localparams;
  - ALU opcode constants ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRL 6'b000010, SRA 6'b000011, also used by the ALU and benches;
  - flags-byte bit positions: ZERO_BIT = 0, CARRY_BIT = 1.
- Single FSM module with no sub-module. ALU and UART instances live in the top-level wrapper, not here.

## Test plan
- A = 0x05, B = 0x03, op = 0x20 -> tx bytes 0x08 then 0x00.
- A = 0xFF, B = 0x01, op = 0x20 -> tx bytes 0x00 then 0x03 (carry and zero).
- A = 0x03, B = 0x05, op = 0x22 -> tx bytes 0xFE then 0x02 (borrow).
- Send A = 0x11, pulse reset, then A = 0x80, B = 0x02, op = 0x03 -> tx bytes 0xE0 then 0x00; alu_a = 0x80.
- During WAIT_RES, inject rx_done_tick with 0x55 -> dropped. The next triple 0x0F, 0xF0, 0x24 yields 0x00 then 0x01.
- Throughout every scenario, the checker asserts that tx_start pulse width is 1 cycle and that tx_data is stable from tx_start to tx_done_tick. Hold tx_done_tick low for 100 cycles -> no second tx_start.

Source files
------------

// File: rtl/alu_uart_if_pkg.sv
// Shared constants for the UART-to-ALU sequencer: FSM encoding, ALU opcodes
// and the bit layout of the flags byte returned over the UART.
package alu_uart_if_pkg;

  localparam logic [2:0] WAIT_A   = 3'd0;
  localparam logic [2:0] WAIT_B   = 3'd1;
  localparam logic [2:0] WAIT_OP  = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] SEND_RES = 3'd4;
  localparam logic [2:0] WAIT_RES = 3'd5;
  localparam logic [2:0] SEND_FLG = 3'd6;
  localparam logic [2:0] WAIT_FLG = 3'd7;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  localparam int ZERO_BIT  = 0;
  localparam int CARRY_BIT = 1;

endpackage

// File: rtl/alu_uart_if.sv
// Sequencer between UART RX/TX and the ALU: receives A, B, opcode, latches the
// ALU result and flags, then transmits the result byte followed by the flags byte.
module alu_uart_if
  import alu_uart_if_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_done_tick,
  input  logic [N-1:0] rx_data,
  input  logic         tx_done_tick,
  output logic         tx_start,
  output logic [N-1:0] tx_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_carry
);

  logic [2:0]   state_reg;
  logic [N-1:0] res_reg;
  logic [N-1:0] flg_reg;
  logic [N-1:0] flg_next;

  always_comb begin
    flg_next            = '0;
    flg_next[ZERO_BIT]  = alu_zero;
    flg_next[CARRY_BIT] = alu_carry;
  end

  // tx_start is raised on the edge that loads tx_data, so the byte is already
  // stable for the whole pulse and until the matching tx_done_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WAIT_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_reg   <= '0;
      flg_reg   <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_reg)
        WAIT_A: begin
          if (rx_done_tick) begin
            alu_a     <= rx_data;
            state_reg <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done_tick) begin
            alu_b     <= rx_data;
            state_reg <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op    <= rx_data[5:0];
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          res_reg   <= alu_result;
          flg_reg   <= flg_next;
          tx_data   <= alu_result;
          tx_start  <= 1'b1;
          state_reg <= SEND_RES;
        end
        SEND_RES: begin
          state_reg <= WAIT_RES;
        end
        WAIT_RES: begin
          tx_data <= res_reg;
          if (tx_done_tick) begin
            state_reg <= SEND_FLG;
          end
        end
        SEND_FLG: begin
          tx_data   <= flg_reg;
          tx_start  <= 1'b1;
          state_reg <= WAIT_FLG;
        end
        WAIT_FLG: begin
          if (tx_done_tick) begin
            state_reg <= WAIT_A;
          end
        end
        default: begin
          state_reg <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_if.sv
// Scoreboard bench for alu_uart_if with a behavioural ALU and a simple UART TX responder.
module tb_alu_uart_if;
  import alu_uart_if_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_done_tick = 1'b0;
  logic [N-1:0] rx_data = '0;
  logic         tx_done_tick = 1'b0;
  logic         tx_start;
  logic [N-1:0] tx_data;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [5:0]   alu_op;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic         alu_carry;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_uart_if #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .tx_done_tick(tx_done_tick),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .alu_carry(alu_carry)
  );

  // Behavioural ALU: shifts move A by B[2:0]; undefined opcodes give 0.
  always_comb begin
    logic [N:0] wide;
    wide      = '0;
    alu_carry = 1'b0;
    case (alu_op)
      ADD: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_carry = wide[N]; end
      SUB: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_carry = wide[N]; end
      AND: wide = {1'b0, alu_a & alu_b};
      OR:  wide = {1'b0, alu_a | alu_b};
      XOR: wide = {1'b0, alu_a ^ alu_b};
      NOR: wide = {1'b0, ~(alu_a | alu_b)};
      SRL: wide = {1'b0, alu_a >> alu_b[2:0]};
      SRA: wide = {1'b0, $signed(alu_a) >>> alu_b[2:0]};
      default: wide = '0;
    endcase
    alu_result = wide[N-1:0];
    alu_zero   = (alu_result == '0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops plus pulse-width, overlap and stability checks.
  logic         prev_start = 1'b0;
  logic         in_flight = 1'b0;
  logic [N-1:0] held_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      in_flight  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        logic has_exp;
        logic [N-1:0] e;
        check_val("start_width", {31'd0, prev_start}, 32'd0);
        check_val("start_overlap", {31'd0, in_flight}, 32'd0);
        has_exp = (exp_q.size() > 0);
        check_val("sb_has_exp", {31'd0, has_exp}, 32'd1);
        if (has_exp) begin
          e = exp_q.pop_front();
          check_val("tx_byte", {24'd0, tx_data}, {24'd0, e});
          $display("tx byte 0x%02h (expected 0x%02h)", tx_data, e);
        end
        in_flight = 1'b1;
        held_data = tx_data;
      end else if (in_flight && tx_done_tick) begin
        check_val("tx_data_stable", {24'd0, tx_data}, {24'd0, held_data});
        in_flight = 1'b0;
      end
      prev_start = tx_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [N-1:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  // Counts edges from a pulse driven in the previous cycle until tx_start is seen.
  task automatic expect_start(input string tag);
    int cnt;
    cnt = 1;
    while (!tx_start && cnt < 20) begin
      tick();
      cnt++;
    end
    check_val(tag, cnt, 2);
  endtask

  task automatic pulse_done(input bit with_rx, input logic [N-1:0] rx_b);
    tx_done_tick = 1'b1;
    if (with_rx) begin
      rx_data      = rx_b;
      rx_done_tick = 1'b1;
    end
    tick();
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
  endtask

  task automatic run_triple(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] op,
                            input logic [N-1:0] exp_res, input logic [N-1:0] exp_flg,
                            input int res_hold, input bit inject);
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_flg);
    $display("triple A=0x%02h B=0x%02h op=0x%02h", a, b, op);
    send_byte(a);
    repeat (2) tick();
    send_byte(b);
    tick();
    tx_done_tick = 1'b1;  // stray done while receiving must be ignored
    send_byte(op);
    tx_done_tick = 1'b0;
    expect_start("res_latency");
    repeat (res_hold) tick();
    if (inject) begin
      send_byte(8'h55);
      repeat (2) tick();
    end
    pulse_done(1'b0, '0);
    expect_start("flg_latency");
    repeat (4) tick();
    pulse_done(inject, 8'h99);
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_val("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check_val("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check_val("rst_alu_op", {26'd0, alu_op}, 32'd0);

    run_triple(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 3, 1'b0);
    run_triple(8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 3, 1'b0);
    run_triple(8'h03, 8'h05, 8'h22, 8'hFE, 8'h02, 3, 1'b0);

    // Partial triple discarded by reset.
    send_byte(8'h11);
    tick();
    check_val("partial_a", {24'd0, alu_a}, 32'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    check_val("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    run_triple(8'h80, 8'h02, 8'h03, 8'hE0, 8'h00, 3, 1'b0);
    check_val("sra_alu_a", {24'd0, alu_a}, 32'h80);

    // Bytes arriving during WAIT_RES and with the final tx_done are dropped.
    run_triple(8'hA0, 8'h0C, 8'h26, 8'hAC, 8'h00, 3, 1'b1);
    run_triple(8'h0F, 8'hF0, 8'h24, 8'h00, 8'h01, 3, 1'b0);
    check_val("drop_alu_a", {24'd0, alu_a}, 32'h0F);
    check_val("drop_alu_b", {24'd0, alu_b}, 32'hF0);
    check_val("drop_alu_op", {26'd0, alu_op}, 32'h24);

    // Long transmitter stall, upper opcode bits ignored, undefined opcode, NOR, SRL.
    run_triple(8'h40, 8'h41, 8'hE0, 8'h81, 8'h00, 100, 1'b0);
    check_val("op_upper_ignored", {26'd0, alu_op}, 32'h20);
    run_triple(8'h12, 8'h34, 8'h3F, 8'h00, 8'h01, 2, 1'b0);
    run_triple(8'h0F, 8'h30, 8'h27, 8'hC0, 8'h00, 2, 1'b0);
    run_triple(8'h80, 8'h03, 8'h02, 8'h10, 8'h00, 2, 1'b0);

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
